// File: rtl/parity_stream.sv
// rtl/parity_stream.sv - streaming word/frame parity generator and checker as a one-stage register slice
module parity_stream #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             odd_sel,
  input  logic             chk_en,
  input  logic             clr_cnt,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_par,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_par,
  output logic             m_last,
  output logic             m_err,
  output logic             m_frame_par,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Parity mode captured on the first beat of a frame; held until the frame ends.
  logic mode_q;
  // Running XOR of the data words accepted so far in the current frame.
  logic acc_q;

  logic acc_in;
  logic data_par;
  logic mode_eff;
  logic wp;
  logic err;
  logic acc_next;
  logic frame_par;
  logic cnt_sat;

  // Handshake, word parity, check and frame parity for the beat on the input.
  always_comb begin
    // The slice can take a new beat when empty or when its beat leaves this cycle.
    s_ready   = ~rst & (~m_valid | m_ready);
    acc_in    = s_valid & s_ready;
    data_par  = ^s_data;
    // Outside a frame the live select applies; inside, the latched one does.
    mode_eff  = busy ? mode_q : odd_sel;
    wp        = data_par ^ mode_eff;
    err       = chk_en & (s_par != wp);
    // A new frame restarts the accumulator from this word alone.
    acc_next  = busy ? (acc_q ^ data_par) : data_par;
    // Frame parity is only presented on the closing beat; zero elsewhere.
    frame_par = s_last & (acc_next ^ mode_eff);
    cnt_sat   = &err_cnt;
  end

  // Output register slice: load on accept, drain when downstream takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_par       <= 1'b0;
      m_last      <= 1'b0;
      m_err       <= 1'b0;
      m_frame_par <= 1'b0;
    end else if (acc_in) begin
      m_valid     <= 1'b1;
      m_data      <= s_data;
      m_par       <= wp;
      m_last      <= s_last;
      m_err       <= err;
      m_frame_par <= frame_par;
    end else if (m_valid & m_ready) begin
      // Payload fields hold their last value; only the valid flag drops.
      m_valid     <= 1'b0;
    end
  end

  // Frame tracking: busy flag, latched mode and running accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      mode_q <= 1'b0;
      acc_q  <= 1'b0;
    end else if (acc_in) begin
      if (s_last) begin
        // Frame closes here (including single-beat frames): back to idle.
        busy  <= 1'b0;
        acc_q <= 1'b0;
      end else begin
        busy  <= 1'b1;
        acc_q <= acc_next;
        if (!busy) begin
          mode_q <= odd_sel;
        end
      end
    end
  end

  // Saturating mismatch counter; a clear request wins over a same-cycle error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (acc_in && err && !cnt_sat) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_parity_stream.sv
// tb/tb_parity_stream.sv - self-checking bench for parity_stream
module tb_parity_stream;

  logic       clk;
  logic       rst;
  logic       odd_sel;
  logic       chk_en;
  logic       clr_cnt;
  logic       s_valid;
  logic [8:0] s_data;
  logic       s_par;
  logic       s_last;
  logic       m_ready;

  logic        s_ready, m_valid, m_par, m_last, m_err, m_frame_par, busy;
  logic [8:0]  m_data;
  logic [15:0] err_cnt;

  logic        s_ready2, m_valid2, m_par2, m_last2, m_err2, m_frame_par2, busy2;
  logic [8:0]  m_data2;
  logic [1:0]  err_cnt2;

  parity_stream #(.WIDTH(9), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .odd_sel(odd_sel), .chk_en(chk_en), .clr_cnt(clr_cnt),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_par(s_par), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_par(m_par), .m_last(m_last),
    .m_err(m_err), .m_frame_par(m_frame_par), .err_cnt(err_cnt), .busy(busy)
  );

  parity_stream #(.WIDTH(9), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .odd_sel(odd_sel), .chk_en(chk_en), .clr_cnt(clr_cnt),
    .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_par(s_par), .s_last(s_last),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_par(m_par2), .m_last(m_last2),
    .m_err(m_err2), .m_frame_par(m_frame_par2), .err_cnt(err_cnt2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Reference model: frame kept as a list of words, parities from ones counts.
  bit         exp_valid, exp_par, exp_last, exp_err, exp_fpar;
  bit         in_frame, frame_odd;
  logic [8:0] exp_data;
  int         exp_cnt, exp_cnt2;
  logic [8:0] frame_words[$];

  task automatic model_step();
    bit take;
    bit err_now;
    int ones;
    int wpar;
    if (rst) begin
      exp_valid = 0; exp_par = 0; exp_last = 0; exp_err = 0; exp_fpar = 0;
      exp_data = '0; in_frame = 0; frame_odd = 0; exp_cnt = 0; exp_cnt2 = 0;
      frame_words.delete();
      return;
    end
    take = s_valid && (!exp_valid || m_ready);
    err_now = 0;
    if (take) begin
      if (!in_frame) begin
        frame_odd = odd_sel;
        frame_words.delete();
      end
      frame_words.push_back(s_data);
      ones = 0;
      foreach (frame_words[i]) ones += $countones(frame_words[i]);
      wpar = ($countones(s_data) + int'(frame_odd)) % 2;
      exp_data  = s_data;
      exp_par   = (wpar == 1);
      exp_last  = s_last;
      err_now   = chk_en && (s_par != (wpar == 1));
      exp_err   = err_now;
      exp_fpar  = s_last && (((ones + int'(frame_odd)) % 2) == 1);
      exp_valid = 1;
      in_frame  = !s_last;
    end else if (m_ready) begin
      exp_valid = 0;
    end
    if (clr_cnt) begin
      exp_cnt = 0;
      exp_cnt2 = 0;
    end else if (err_now) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("s_ready", 32'(s_ready), 32'(!rst && (!exp_valid || m_ready)));
    chk("m_valid", 32'(m_valid), 32'(exp_valid));
    chk("m_data", 32'(m_data), 32'(exp_data));
    chk("m_par", 32'(m_par), 32'(exp_par));
    chk("m_last", 32'(m_last), 32'(exp_last));
    chk("m_err", 32'(m_err), 32'(exp_err));
    chk("m_frame_par", 32'(m_frame_par), 32'(exp_fpar));
    chk("busy", 32'(busy), 32'(in_frame));
    chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
    chk("c2_m_valid", 32'(m_valid2), 32'(exp_valid));
    chk("c2_m_frame_par", 32'(m_frame_par2), 32'(exp_fpar));
    chk("c2_err_cnt", 32'(err_cnt2), 32'(exp_cnt2));
  end

  // Delivered-beat log for the backpressure sequence.
  bit         mon_en = 0;
  logic [8:0] got_q[$];
  always @(negedge clk) begin
    if (mon_en && m_valid && m_ready) got_q.push_back(m_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [8:0] d, input logic l, input logic p);
    s_valid = 1; s_data = d; s_last = l; s_par = p;
    step();
    s_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  logic [8:0] bp_words[4];

  initial begin
    rst = 1; odd_sel = 0; chk_en = 0; clr_cnt = 0;
    s_valid = 0; s_data = '0; s_par = 0; s_last = 0; m_ready = 1;
    step(); step();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 0;
    step();

    // Even mode, all ones word
    odd_sel = 0;
    beat(9'h1FF, 1, 0);
    chk("t1_m_valid", 32'(m_valid), 32'd1);
    chk("t1_m_data", 32'(m_data), 32'h1FF);
    chk("t1_m_par", 32'(m_par), 32'd1);
    chk("t1_m_frame_par", 32'(m_frame_par), 32'd1);
    step();

    // Odd mode back-to-back beats
    odd_sel = 1;
    beat(9'h003, 1, 0);
    chk("t2_par_a", 32'(m_par), 32'd1);
    beat(9'h007, 1, 0);
    chk("t2_par_b", 32'(m_par), 32'd0);
    chk("t2_valid_b", 32'(m_valid), 32'd1);
    chk("t2_data_b", 32'(m_data), 32'h007);
    step();

    // Parity check and error counting
    odd_sel = 0; chk_en = 1;
    beat(9'h001, 1, 0);
    chk("t3_err_a", 32'(m_err), 32'd1);
    chk("t3_cnt_a", 32'(err_cnt), 32'd1);
    beat(9'h001, 1, 1);
    chk("t3_err_b", 32'(m_err), 32'd0);
    chk("t3_cnt_b", 32'(err_cnt), 32'd1);
    chk_en = 0;
    step();

    // Three-beat even frame with a mid-frame mode change
    odd_sel = 0;
    beat(9'h001, 0, 0);
    chk("t4_par1", 32'(m_par), 32'd1);
    chk("t4_fp1", 32'(m_frame_par), 32'd0);
    chk("t4_busy1", 32'(busy), 32'd1);
    odd_sel = 1;
    beat(9'h003, 0, 0);
    chk("t4_par2", 32'(m_par), 32'd0);
    chk("t4_fp2", 32'(m_frame_par), 32'd0);
    beat(9'h000, 1, 0);
    chk("t4_par3", 32'(m_par), 32'd0);
    chk("t4_fp3", 32'(m_frame_par), 32'd1);
    chk("t4_busy3", 32'(busy), 32'd0);
    odd_sel = 0;
    step();

    // Backpressure: four-beat frame, downstream stalled for three cycles
    bp_words[0] = 9'h0A5; bp_words[1] = 9'h15A; bp_words[2] = 9'h100; bp_words[3] = 9'h0FF;
    got_q.delete();
    mon_en = 1;
    m_ready = 0;
    s_valid = 1; s_data = bp_words[0]; s_last = 0; s_par = 0;
    step();
    s_data = bp_words[1];
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_stall_ready", 32'(s_ready), 32'd0);
      chk("t5_stall_data", 32'(m_data), 32'h0A5);
      chk("t5_stall_valid", 32'(m_valid), 32'd1);
    end
    m_ready = 1;
    step();
    s_data = bp_words[2];
    step();
    s_data = bp_words[3]; s_last = 1;
    step();
    chk("t5_fp", 32'(m_frame_par), 32'(($countones(9'h0A5) + $countones(9'h15A) + $countones(9'h100) + $countones(9'h0FF)) % 2));
    s_valid = 0; s_last = 0;
    step(); step();
    mon_en = 0;
    chk("t5_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) chk("t5_order", 32'(got_q[i]), 32'(bp_words[i]));
      else chk("t5_missing", 32'hFFFF_FFFF, 32'(bp_words[i]));
    end

    // Saturation with CNT_W=2 and clear priority
    clr_cnt = 1;
    step();
    clr_cnt = 0;
    chk("t6_cleared", 32'(err_cnt), 32'd0);
    chk_en = 1; odd_sel = 0;
    for (int i = 0; i < 5; i++) beat(9'h001, 1, 0);
    chk("t6_cnt16", 32'(err_cnt), 32'd5);
    chk("t6_cnt2_sat", 32'(err_cnt2), 32'd3);
    clr_cnt = 1;
    beat(9'h001, 1, 0);
    clr_cnt = 0;
    chk("t6_clr_cnt16", 32'(err_cnt), 32'd0);
    chk("t6_clr_cnt2", 32'(err_cnt2), 32'd0);
    chk("t6_clr_err", 32'(m_err), 32'd1);
    beat(9'h001, 1, 0);
    chk("t6_after_clr", 32'(err_cnt2), 32'd1);
    chk_en = 0;
    step();

    // Reset in the middle of a frame
    odd_sel = 0;
    beat(9'h001, 0, 0);
    chk("t7_busy_pre", 32'(busy), 32'd1);
    rst = 1;
    #1;
    chk("t7_rst_valid", 32'(m_valid), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_data", 32'(m_data), 32'd0);
    chk("t7_rst_cnt", 32'(err_cnt), 32'd0);
    chk("t7_rst_ready", 32'(s_ready), 32'd0);
    step();
    rst = 0;
    odd_sel = 1;
    beat(9'h003, 1, 0);
    chk("t7_new_par", 32'(m_par), 32'd1);
    chk("t7_new_fp", 32'(m_frame_par), 32'd1);
    chk("t7_new_busy", 32'(busy), 32'd0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
